// File: rtl/dist_alarm.sv
// Distance alarm: filters ranging samples, tracks a hysteretic FAULT/SAFE/WARN/DANGER zone, drives RGB LEDs and buzzer.
// Optional 4-sample averaging window is built when DIST_ALARM_AVG_EN is defined.
module dist_alarm #(
  parameter int CLK_HZ      = 50000000,
  parameter int NEAR_CM     = 10,
  parameter int FAR_CM      = 30,
  parameter int HYST_CM     = 2,
  parameter int TIMEOUT_MS  = 200,
  parameter int BEEP_ON_MS  = 100,
  parameter int BEEP_PER_MS = 500
) (
  input  logic        clk50,
  input  logic        rst,
  input  logic        dist_valid,
  input  logic [15:0] dist_cm,
  output logic        buzzer_en,
  output logic        red_led,
  output logic        green_led,
  output logic        blue_led,
  output logic [1:0]  zone
);

  localparam int TICK_CYC = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int PRE_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int TMO_W    = $clog2(TIMEOUT_MS + 1);
  localparam int PH_W     = (BEEP_PER_MS > 1) ? $clog2(BEEP_PER_MS) : 1;

  localparam logic [15:0] NEAR_T     = 16'(NEAR_CM);
  localparam logic [15:0] FAR_T      = 16'(FAR_CM);
  localparam logic [15:0] NEAR_EXIT  = 16'(NEAR_CM + HYST_CM);
  localparam logic [15:0] FAR_EXIT   = 16'(FAR_CM + HYST_CM);

  typedef enum logic [1:0] {
    Z_FAULT  = 2'd0,
    Z_SAFE   = 2'd1,
    Z_WARN   = 2'd2,
    Z_DANGER = 2'd3
  } zone_t;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [15:0]      avg_q, avg_d;
  logic             avg_vld_q;
  logic             tick_s, expire_s, buzzer_d;
  zone_t            zone_q, zone_d;

  // ms prescaler and sample-gap timeout; a coincident sample suppresses expiry
  always_comb begin
    tick_s   = (pre_q == PRE_W'(TICK_CYC - 1));
    pre_d    = tick_s ? '0 : pre_q + PRE_W'(1);
    expire_s = tick_s && !dist_valid && (tmo_q == TMO_W'(TIMEOUT_MS - 1));
    if (dist_valid) begin
      tmo_d = '0;
    end else if (tick_s && (tmo_q != TMO_W'(TIMEOUT_MS))) begin
      tmo_d = tmo_q + TMO_W'(1);
    end else begin
      tmo_d = tmo_q;
    end
  end

`ifdef DIST_ALARM_AVG_EN
  logic [3:0][15:0] win_q, win_d;
  logic             fresh_q;
  logic [17:0]      sum_s;

  // window reloads with the first sample after reset/FAULT, otherwise shifts
  always_comb begin
    win_d = win_q;
    if (dist_valid && fresh_q) begin
      win_d = {4{dist_cm}};
    end else if (dist_valid) begin
      win_d = {win_q[2:0], dist_cm};
    end else begin
      win_d = win_q;
    end
    sum_s = 18'(win_d[0]) + 18'(win_d[1]) + 18'(win_d[2]) + 18'(win_d[3]);
    avg_d = sum_s[17:2];
  end

  // window storage and reload flag
  always_ff @(posedge clk50) begin
    if (rst) begin
      win_q   <= '0;
      fresh_q <= 1'b1;
    end else begin
      win_q <= win_d;
      if (expire_s) begin
        fresh_q <= 1'b1;
      end else if (dist_valid) begin
        fresh_q <= 1'b0;
      end
    end
  end
`else
  // unfiltered: average is the raw sample
  always_comb begin
    avg_d = dist_cm;
  end
`endif

  // zone next-state, beep phase and buzzer decision
  always_comb begin
    zone_d = zone_q;
    if (avg_vld_q) begin
      case (zone_q)
        Z_WARN:   zone_d = (avg_q < NEAR_T) ? Z_DANGER : (avg_q >= FAR_EXIT) ? Z_SAFE : Z_WARN;
        Z_DANGER: zone_d = (avg_q >= FAR_EXIT) ? Z_SAFE : (avg_q >= NEAR_EXIT) ? Z_WARN : Z_DANGER;
        // FAULT and SAFE both pick the zone straight from the entry thresholds
        default:  zone_d = (avg_q < NEAR_T) ? Z_DANGER : (avg_q < FAR_T) ? Z_WARN : Z_SAFE;
      endcase
    end else if (expire_s) begin
      zone_d = Z_FAULT;
    end else begin
      zone_d = zone_q;
    end
    if ((zone_d == Z_WARN) && (zone_q != Z_WARN)) begin
      phase_d = '0;
    end else if (tick_s) begin
      phase_d = (phase_q == PH_W'(BEEP_PER_MS - 1)) ? '0 : phase_q + PH_W'(1);
    end else begin
      phase_d = phase_q;
    end
    buzzer_d = (zone_d == Z_DANGER) || ((zone_d == Z_WARN) && (phase_d < PH_W'(BEEP_ON_MS)));
  end

  // pipeline, zone state and registered outputs
  always_ff @(posedge clk50) begin
    if (rst) begin
      pre_q     <= '0;
      tmo_q     <= '0;
      phase_q   <= '0;
      avg_q     <= '0;
      avg_vld_q <= 1'b0;
      zone_q    <= Z_FAULT;
      buzzer_en <= 1'b0;
      red_led   <= 1'b0;
      green_led <= 1'b0;
      blue_led  <= 1'b1;
    end else begin
      pre_q     <= pre_d;
      tmo_q     <= tmo_d;
      phase_q   <= phase_d;
      avg_vld_q <= dist_valid;
      if (dist_valid) begin
        avg_q <= avg_d;
      end
      zone_q    <= zone_d;
      buzzer_en <= buzzer_d;
      red_led   <= (zone_d == Z_WARN) || (zone_d == Z_DANGER);
      green_led <= (zone_d == Z_SAFE) || (zone_d == Z_WARN);
      blue_led  <= (zone_d == Z_FAULT);
    end
  end

  assign zone = zone_q;

endmodule
